cond_unit: RTL

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the condition field against the
// architectural flags, gates write enables, and counts decoded/skipped instructions.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        NextPC,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        Decode,
  input  logic        CntClr,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic        CondExReg,
  output logic [15:0] InstrCount,
  output logic [15:0] SkipCount
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  flags_q, flags_d;
  logic        cond_ex;
  logic        cond_ex_q;
  logic [15:0] instr_q, instr_d;
  logic [15:0] skip_q, skip_d;
  logic        n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b1;
    unique case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      default: cond_ex = 1'b1;
    endcase
  end

  // Flag writes belong to the instruction in flight, never to the one being decoded.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_q && !Decode) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_comb begin
    instr_d = instr_q;
    skip_d  = skip_q;
    if (CntClr) begin
      instr_d = 16'h0000;
      skip_d  = 16'h0000;
    end else if (Decode) begin
      if (instr_q != 16'hFFFF) instr_d = instr_q + 16'd1;
      if (!cond_ex && skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
      instr_q   <= 16'h0000;
      skip_q    <= 16'h0000;
    end else begin
      flags_q <= flags_d;
      instr_q <= instr_d;
      skip_q  <= skip_d;
      // A clear returns to IDLE even if a decode arrives in the same cycle.
      if (CntClr) begin
        state_q   <= IDLE;
        cond_ex_q <= 1'b0;
      end else if (Decode) begin
        state_q   <= RUN;
        cond_ex_q <= cond_ex;
      end
    end
  end

  assign PCWrite    = NextPC | (PCS & cond_ex_q);
  assign RegWrite   = RegW & cond_ex_q;
  assign MemWrite   = MemW & cond_ex_q;
  assign Flags      = flags_q;
  assign CondExReg  = cond_ex_q & (state_q == RUN);
  assign InstrCount = instr_q;
  assign SkipCount  = skip_q;

endmodule
